muldiv_unit: RTL and testbench

Iterative RV32M execution unit, directly downstream of the RV32M decoder. Accepts a decoded operation (`control_md` plus operand signedness) and both register operands. Computes MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU over 32 sequential iterations. Returns a 32-bit writeback value with a one-cycle `done` pulse.

---
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply / divide execution unit.
// Multiplies by unsigned shift-add and divides by restoring division, both
// working on operand magnitudes for 32 iterations, then fixes up the signs in
// a final FIX cycle and pulses done with the 32-bit writeback value.
// Optional build macro: MULDIV_DIV0_FAST_EN -- when defined, a DIV/REM whose
// divisor is zero skips the iterations and goes straight to FIX.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  control_md,
  input  logic        rs1_sign,
  input  logic        rs2_sign,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude of x when neg is set, x itself otherwise.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    logic [31:0] m;
    if (neg) begin
      m = ~x + 32'd1;
    end else begin
      m = x;
    end
    return m;
  endfunction

  // Architectural state
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;       // control_md[1:0]: 0 MUL, 1 MULH*, 2 DIV*, 3 REM*
  logic        neg_p_q;    // final product / quotient is negative
  logic        sa_q;       // dividend was negative -> remainder negative
  logic        div0_q;     // divide by zero, result comes from fixed rule
  logic [31:0] dvd_raw_q;  // raw rs1 value, returned by REM on divide by zero
  logic [31:0] mcand_q;    // |multiplicand| for MUL, |divisor| for DIV
  logic [63:0] work_q;     // MUL: {acc, multiplier}; DIV: low word shifts dividend out / quotient in
  logic [31:0] rem_q;      // DIV partial remainder (always below the divisor)
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  // Request decode and operand preparation
  logic        req_valid_s;
  logic        accept_s;
  logic        sa_s;
  logic        sb_s;
  logic [31:0] mag1_s;
  logic [31:0] mag2_s;
  logic        div0_req_s;

  // Iteration datapath
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_trial_s;
  logic        div_ge_s;
  logic [31:0] div_rem_next_s;
  logic [31:0] div_quot_next_s;

  // Sign fix-up
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] fix_result_s;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Decode the incoming request and derive operand signs and magnitudes.
  always_comb begin
    req_valid_s = (control_md[7:2] == 6'b000111);
    accept_s    = start && (state_q == ST_IDLE) && req_valid_s;
    sa_s        = rs1_sign & rs1_data[31];
    sb_s        = rs2_sign & rs2_data[31];
    mag1_s      = mag32(rs1_data, sa_s);
    mag2_s      = mag32(rs2_data, sb_s);
    div0_req_s  = control_md[1] && (rs2_data == 32'd0);
  end

  // One shift-add multiply step and one restoring divide step per cycle.
  always_comb begin
    mul_sum_s   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mcand_q} : 33'd0);
    mul_next_s  = {mul_sum_s, work_q[31:1]};
    div_shift_s = {rem_q, work_q[31]};
    div_trial_s = div_shift_s - {1'b0, mcand_q};
    // The shifted remainder is below twice the divisor, so bit 32 of the
    // trial difference is set exactly when the subtraction went negative.
    div_ge_s    = ~div_trial_s[32];
    if (div_ge_s) begin
      div_rem_next_s = div_trial_s[31:0];
    end else begin
      div_rem_next_s = div_shift_s[31:0];
    end
    div_quot_next_s = {work_q[30:0], div_ge_s};
  end

  // Apply result signs and select the writeback word for the latched op.
  always_comb begin
    prod_fix_s = neg_p_q ? (~work_q + 64'd1) : work_q;
    quot_fix_s = neg_p_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix_s  = sa_q ? (~rem_q + 32'd1) : rem_q;
    case (op_q)
      2'b00:   fix_result_s = prod_fix_s[31:0];
      2'b01:   fix_result_s = prod_fix_s[63:32];
      2'b10:   fix_result_s = div0_q ? 32'hFFFF_FFFF : quot_fix_s;
      2'b11:   fix_result_s = div0_q ? dvd_raw_q : rem_fix_s;
      default: fix_result_s = 32'd0;
    endcase
  end

  // Control FSM with registered busy/done/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      neg_p_q   <= 1'b0;
      sa_q      <= 1'b0;
      div0_q    <= 1'b0;
      dvd_raw_q <= 32'd0;
      mcand_q   <= 32'd0;
      work_q    <= 64'd0;
      rem_q     <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          cnt_q  <= 6'd0;
          if (accept_s) begin
            op_q      <= control_md[1:0];
            neg_p_q   <= sa_s ^ sb_s;
            sa_q      <= sa_s;
            div0_q    <= div0_req_s;
            dvd_raw_q <= rs1_data;
            rem_q     <= 32'd0;
            if (control_md[1]) begin
              mcand_q <= mag2_s;
              work_q  <= {32'd0, mag1_s};
            end else begin
              mcand_q <= mag1_s;
              work_q  <= {32'd0, mag2_s};
            end
`ifdef MULDIV_DIV0_FAST_EN
            // Divide by zero needs no iterations; busy rises with done.
            if (div0_req_s) begin
              state_q <= ST_FIX;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
            end
`else
            state_q <= ST_CALC;
            busy_q  <= 1'b1;
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end

        ST_CALC: begin
          if (op_q[1]) begin
            work_q <= {32'd0, div_quot_next_s};
            rem_q  <= div_rem_next_s;
          end else begin
            work_q <= mul_next_s;
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_CALC;
          end
        end

        ST_FIX: begin
          result_q <= fix_result_s;
          done_q   <= 1'b1;
          busy_q   <= 1'b1;
          cnt_q    <= 6'd0;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Stimulus pushes the
// expected result and latency computed with plain 64-bit arithmetic; an
// independent monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  control_md;
  logic        rs1_sign;
  logic        rs2_sign;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .control_md (control_md),
    .rs1_sign   (rs1_sign),
    .rs2_sign   (rs2_sign),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges; used to measure latency from the accepting edge.
  always @(posedge clk) cyc <= cyc + 1;

  // RV32M reference: operands extended per sign flag, exact 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [7:0] md, input logic s1, input logic s2,
                                            input logic [31:0] a, input logic [31:0] b);
    longint av, bv, p, q, r;
    av = s1 ? longint'($signed(a)) : longint'({32'd0, a});
    bv = s2 ? longint'($signed(b)) : longint'({32'd0, b});
    p  = av * bv;
    if (md == 8'h1c) return p[31:0];
    if (md == 8'h1d) return p[63:32];
    if (b == 32'd0) begin
      if (md == 8'h1e) return 32'hFFFF_FFFF;
      return a;
    end
    q = av / bv;
    r = av % bv;
    if (md == 8'h1e) return q[31:0];
    return r[31:0];
  endfunction

  function automatic int exp_lat(input logic [7:0] md, input logic [31:0] b);
`ifdef MULDIV_DIV0_FAST_EN
    if (md[1] && (b == 32'd0)) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Drive one request for a single edge; optionally record its expectation.
  task automatic issue(input logic [7:0] md, input logic s1, input logic s2,
                       input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    control_md = md;
    rs1_sign   = s1;
    rs2_sign   = s2;
    rs1_data   = a;
    rs2_data   = b;
    start      = 1'b1;
    if (push) begin
      e.res       = ref_model(md, s1, s2, a, b);
      e.start_cyc = cyc + 1;
      e.lat       = exp_lat(md, b);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results still outstanding", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (done === 1'b1)) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got result %h, required no done", result);
        end else begin
          mon_e = sb_q.pop_front();
          chk("result", result, mon_e.res);
          chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  initial begin
    logic [7:0]  md;
    logic [31:0] a;
    logic [31:0] b;
    rst        = 1'b1;
    start      = 1'b0;
    control_md = 8'h00;
    rs1_sign   = 1'b0;
    rs2_sign   = 1'b0;
    rs1_data   = 32'd0;
    rs2_data   = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // MUL 7 * -3 with busy held through the iterations
    issue(8'h1c, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("busy_calc", {31'd0, busy}, 32'd1);
    end
    wait_idle();

    // Directed corner cases, issued back-to-back after each done
    issue(8'h1d, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(8'h1d, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(8'h1d, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1);         wait_idle();
    issue(8'h1e, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_idle();
    issue(8'h1f, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);         wait_idle();
    issue(8'h1e, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(8'h1f, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(8'h1e, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd2, 1'b1);         wait_idle();
    issue(8'h1e, 1'b1, 1'b1, 32'd5, 32'd0, 1'b1);                 wait_idle();
    issue(8'h1f, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1);         wait_idle();

    // A second start during an op is ignored
    issue(8'h1e, 1'b1, 1'b1, 32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    #1;
    issue(8'h1c, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);
    chk("busy_after_ignored", {31'd0, busy}, 32'd0);

    // Non-M control_md produces neither busy nor done
    #1;
    issue(8'h00, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_noop", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of a divide, then a fresh multiply
    #1;
    issue(8'h1e, 1'b0, 1'b0, 32'd1000, 32'd3, 1'b1);
    repeat (14) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    issue(8'h1c, 1'b0, 1'b0, 32'd3, 32'd4, 1'b1);
    wait_idle();

    // Randomized operations against the arithmetic reference
    for (int n = 0; n < 40; n++) begin
      md = 8'h1c + 8'($urandom_range(0, 3));
      a  = rand_opnd();
      b  = rand_opnd();
      issue(md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
